// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: sizes and FSM encoding.
package rr_arbiter8_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter8_if;
  import rr_arbiter8_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/rr_arbiter8_decoder3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module rr_arbiter8_decoder3to8
  import rr_arbiter8_pkg::*;
(
  input  logic               i_en,
  input  logic [IDX_W-1:0]   i_idx,
  output logic [NUM_REQ-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with a registered winner index, a rotating
// fairness pointer and an optional maximum hold time per grant.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter8_if.slave  bus
);

  if ((64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cnt_w
    $error("rr_arbiter8: CNT_W too narrow for MAX_HOLD");
  end

  localparam logic [CNT_W-1:0] HoldLimit = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CntSat    = {CNT_W{1'b1}};

  // First set request bit scanning ptr, ptr+1, ... ptr+7 (mod 8).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  arb_state_e       r_state;
  arb_state_e       w_state_d;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_d;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_d;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_cnt_d;
  logic             r_timeout;
  logic             w_timeout_d;

  logic [IDX_W-1:0]   w_pick;
  logic               w_rel_normal;
  logic               w_rel_tmo;
  logic               w_valid;
  logic [NUM_REQ-1:0] w_gnt;

  assign w_pick       = rr_pick(bus.req, r_ptr);
  assign w_rel_normal = bus.done || !bus.req[r_idx];
  assign w_rel_tmo    = (MAX_HOLD != 0) && (r_hold_cnt == HoldLimit);
  assign w_valid      = (r_state == StGrant);

  always_comb begin
    w_state_d    = r_state;
    w_idx_d      = r_idx;
    w_ptr_d      = r_ptr;
    w_hold_cnt_d = r_hold_cnt;
    w_timeout_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|bus.req) begin
          w_state_d    = StGrant;
          w_idx_d      = w_pick;
          w_hold_cnt_d = CNT_W'(1);
        end
      end
      StGrant: begin
        if (w_rel_normal || w_rel_tmo) begin
          w_state_d    = StIdle;
          w_ptr_d      = r_idx + IDX_W'(1);
          w_hold_cnt_d = '0;
          // A normal release wins over a coincident hold expiry.
          w_timeout_d  = !w_rel_normal;
        end else if (r_hold_cnt != CntSat) begin
          w_hold_cnt_d = r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_idx      <= w_idx_d;
      r_ptr      <= w_ptr_d;
      r_hold_cnt <= w_hold_cnt_d;
      r_timeout  <= w_timeout_d;
    end
  end

  rr_arbiter8_decoder3to8 u_dec (
    .i_en     (w_valid),
    .i_idx    (r_idx),
    .o_onehot (w_gnt)
  );

  assign bus.gnt       = w_gnt;
  assign bus.gnt_idx   = r_idx;
  assign bus.gnt_valid = w_valid;
  assign bus.timeout   = r_timeout;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.gnt));
  a_tmo_idle:   assert property (@(posedge clk) disable iff (!rst_n)
                                 bus.timeout |-> !bus.gnt_valid);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: vector table through a scoreboard queue plus
// hand-written reset sequences.
module tb_rr_arbiter8;
  import rr_arbiter8_pkg::*;

  logic clk;
  logic rst_n;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(
    .MAX_HOLD (4),
    .CNT_W    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic [7:0] req, input logic done, input logic [7:0] gnt,
                              input logic [2:0] idx, input logic valid, input logic tmo);
    vec_t v;
    v.req   = req;
    v.done  = done;
    v.gnt   = gnt;
    v.idx   = idx;
    v.valid = valid;
    v.tmo   = tmo;
    return v;
  endfunction

  task automatic add(input logic [7:0] req, input logic done, input logic [7:0] gnt,
                     input logic [2:0] idx, input logic valid, input logic tmo);
    vecs.push_back(mk(req, done, gnt, idx, valid, tmo));
  endtask

  task automatic check(input string name, input vec_t e);
    n_cmp++;
    if (bus.gnt !== e.gnt || bus.gnt_idx !== e.idx || bus.gnt_valid !== e.valid ||
        bus.timeout !== e.tmo) begin
      n_bad++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b tmo=%b, want gnt=%h idx=%0d valid=%b tmo=%b",
               name, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout,
               e.gnt, e.idx, e.valid, e.tmo);
    end
  endtask

  // Inputs change on the falling edge; the result of the next rising edge is checked 1 ns later.
  task automatic step(input string name, input vec_t v);
    vec_t e;
    @(negedge clk);
    bus.req  = v.req;
    bus.done = v.done;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(name, e);
  endtask

  initial begin
    logic [7:0] oh;

    rst_n    = 1'b0;
    bus.req  = 8'hFF;
    bus.done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", mk(8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_grant", mk(8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));

    // Full rotation with every requester active, done one cycle into each grant.
    for (int i = 0; i < 8; i++) begin
      oh = 8'(1 << i);
      if (i > 0) add(8'hFF, 1'b0, oh, 3'(i), 1'b1, 1'b0);
      add(8'hFF, 1'b1, 8'h00, 3'(i), 1'b0, 1'b0);
    end
    add(8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    // ptr=1: index 2 first, then from ptr=3 index 7 beats index 2, then wrap to 0.
    add(8'h84, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    add(8'h84, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
    add(8'h84, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
    add(8'h84, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0);
    add(8'h84, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    // Owner 2 withdraws: plain release, ptr becomes 3 so index 3 beats index 2.
    add(8'h80, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0);
    add(8'h0C, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    add(8'h0C, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);
    add(8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);
    // Sole requester 4 held to MAX_HOLD=4, timeout pulse, regrant after the dead cycle.
    for (int i = 0; i < 4; i++) add(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
    add(8'h10, 1'b0, 8'h00, 3'd4, 1'b0, 1'b1);
    add(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
    // Other bits toggle during the grant, then done coincides with the hold limit.
    add(8'h1F, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
    add(8'h90, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
    add(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
    add(8'h10, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0);
    add(8'hFF, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset in the middle of the grant to requester 5.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", mk(8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    @(negedge clk);
    bus.req = 8'h21;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_ptr0", mk(8'h21, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
    step("post_reset_rel", mk(8'h21, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
    step("post_reset_req5", mk(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
